// File: rtl/pll_reset_sequencer.sv
// Reset/lock supervisor for the PLL wrapper: pulses the PLL reset, waits for stable
// synchronized lock, holds the system reset for a settle time, and retries on loss or timeout.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES        = 32,
  parameter int unsigned LOCK_TIMEOUT       = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_locked,
  output logic       o_pll_rst,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic       o_lock_lost,
  output logic [3:0] o_retry_count,
  output logic [1:0] o_state
);

  localparam int unsigned MAX_A      = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_B      = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] C_PLL_RST = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [CNT_W-1:0] r_timeout_cnt;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] w_stable_nxt;
  logic [CNT_W-1:0] w_timeout_nxt;
  logic [CNT_W-1:0] w_phase_inc;
  logic [CNT_W-1:0] w_stable_inc;
  logic [CNT_W-1:0] w_timeout_inc;

  logic [3:0] r_retry_count;
  logic [3:0] w_retry_nxt;
  logic       r_pll_rst;
  logic       r_sys_reset;
  logic       r_ready;
  logic       r_lock_lost;
  logic       w_lock_lost_nxt;

  // Only the last synchronizer stage is ever looked at; the raw input feeds nothing else.
  assign w_locked_s    = r_sync[SYNC_STAGES-1];
  assign w_phase_inc   = r_phase_cnt + CNT_W'(1);
  assign w_stable_inc  = w_locked_s ? (r_stable_cnt + CNT_W'(1)) : '0;
  assign w_timeout_inc = r_timeout_cnt + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase_cnt;
    w_stable_nxt    = r_stable_cnt;
    w_timeout_nxt   = r_timeout_cnt;
    w_retry_nxt     = r_retry_count;
    w_lock_lost_nxt = r_lock_lost;

    unique case (r_state)
      ST_PLL_RST: begin
        w_stable_nxt  = '0;
        w_timeout_nxt = '0;
        if (w_phase_inc == C_PLL_RST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = w_phase_inc;
        end
      end

      ST_WAIT_LOCK: begin
        w_stable_nxt  = w_stable_inc;
        w_timeout_nxt = w_timeout_inc;
        // Stable lock takes priority over a timeout landing on the same cycle.
        if (w_stable_inc == C_STABLE) begin
          w_state_nxt = ST_HOLD;
          w_phase_nxt = '0;
        end else if (w_timeout_inc == C_TIMEOUT) begin
          w_state_nxt = ST_PLL_RST;
          w_phase_nxt = '0;
          if (r_retry_count != 4'hF) w_retry_nxt = r_retry_count + 4'd1;
        end
      end

      ST_HOLD: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_PLL_RST;
          w_phase_nxt = '0;
        end else if (w_phase_inc == C_HOLD) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = w_phase_inc;
        end
      end

      ST_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt     = ST_PLL_RST;
          w_phase_nxt     = '0;
          w_lock_lost_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_PLL_RST;
        w_phase_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_PLL_RST;
      r_sync        <= '0;
      r_phase_cnt   <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_retry_count <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sync        <= {r_sync[SYNC_STAGES-2:0], i_locked};
      r_phase_cnt   <= w_phase_nxt;
      r_stable_cnt  <= w_stable_nxt;
      r_timeout_cnt <= w_timeout_nxt;
      r_retry_count <= w_retry_nxt;
      // Outputs are decoded from the next state so they flip on the same edge as the state.
      r_pll_rst     <= (w_state_nxt == ST_PLL_RST);
      r_sys_reset   <= (w_state_nxt != ST_RUN);
      r_ready       <= (w_state_nxt == ST_RUN);
      r_lock_lost   <= w_lock_lost_nxt;
    end
  end

  assign o_pll_rst     = r_pll_rst;
  assign o_sys_reset   = r_sys_reset;
  assign o_ready       = r_ready;
  assign o_lock_lost   = r_lock_lost;
  assign o_retry_count = r_retry_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; edge E0 is the last edge that samples reset=1,
// and every observation is taken 1 time unit after the edge it describes.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_PLL  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  always #5 clock = ~clock;

  pll_reset_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .i_locked      (locked),
    .o_pll_rst     (pll_rst),
    .o_sys_reset   (sys_reset),
    .o_ready       (ready),
    .o_lock_lost   (lock_lost),
    .o_retry_count (retry_count),
    .o_state       (state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs that follow from the state alone are derived here from the expected state.
  task automatic check_outs(input string tag, input logic [1:0] st, input logic ll, input logic [3:0] rc);
    check({tag, ".state"},     32'(state),       32'(st));
    check({tag, ".pll_rst"},   32'(pll_rst),     32'(st == S_PLL));
    check({tag, ".sys_reset"}, 32'(sys_reset),   32'(st != S_RUN));
    check({tag, ".ready"},     32'(ready),       32'(st == S_RUN));
    check({tag, ".lock_lost"}, 32'(lock_lost),   32'(ll));
    check({tag, ".retry"},     32'(retry_count), 32'(rc));
  endtask

  initial begin
    // ---- Clean power-up with lock constantly high ----
    reset  = 1'b1;
    locked = 1'b1;
    step(3);                                   // E0
    check_outs("reset_vals", S_PLL, 1'b0, 4'd0);
    reset = 1'b0;
    step(15);                                  // E15
    check_outs("pll_rst_E15", S_PLL, 1'b0, 4'd0);
    step(1);                                   // E16
    check_outs("wait_E16", S_WAIT, 1'b0, 4'd0);
    step(63);                                  // E79
    check_outs("wait_E79", S_WAIT, 1'b0, 4'd0);
    step(1);                                   // E80
    check_outs("hold_E80", S_HOLD, 1'b0, 4'd0);
    step(31);                                  // E111
    check_outs("hold_E111", S_HOLD, 1'b0, 4'd0);
    step(1);                                   // E112
    check_outs("run_E112", S_RUN, 1'b0, 4'd0);

    // ---- Lock loss in RUN: reaction exactly SYNC_STAGES+1 edges later ----
    locked = 1'b0;
    step(2);                                   // D2: locked_s just fell
    check_outs("run_loss_D2", S_RUN, 1'b0, 4'd0);
    step(1);                                   // D3: re-entry to PLL_RST
    check_outs("run_loss_D3", S_PLL, 1'b1, 4'd0);
    locked = 1'b1;
    step(16);                                  // D3+16
    check_outs("relock_wait", S_WAIT, 1'b1, 4'd0);
    step(95);                                  // D3+111
    check_outs("relock_hold", S_HOLD, 1'b1, 4'd0);
    step(1);                                   // D3+112
    check_outs("relock_run", S_RUN, 1'b1, 4'd0);

    // ---- Reset clears lock_lost; lock drop during HOLD cycle 10 ----
    reset = 1'b1;
    step(1);                                   // new E0
    check_outs("reset_from_run", S_PLL, 1'b0, 4'd0);
    reset = 1'b0;
    step(80);                                  // E80
    check_outs("hold2_E80", S_HOLD, 1'b0, 4'd0);
    step(9);                                   // E89
    locked = 1'b0;
    step(2);                                   // E91: locked_s just fell
    check_outs("hold2_E91", S_HOLD, 1'b0, 4'd0);
    step(1);                                   // E92 = P, new PLL_RST entry
    check_outs("hold_drop", S_PLL, 1'b0, 4'd0);

    // ---- One-cycle lock glitch at WAIT cycle 40 restarts the stable count ----
    locked = 1'b1;
    step(16);                                  // W = P+16
    check_outs("glitch_wait_entry", S_WAIT, 1'b0, 4'd0);
    step(39);                                  // W+39
    locked = 1'b0;
    step(1);                                   // W+40 samples the low level
    locked = 1'b1;
    step(24);                                  // W+64: would be HOLD without the glitch
    check_outs("glitch_W64", S_WAIT, 1'b0, 4'd0);
    step(41);                                  // W+105
    check_outs("glitch_W105", S_WAIT, 1'b0, 4'd0);
    step(1);                                   // W+106: 64 edges after locked_s recovery
    check_outs("glitch_W106", S_HOLD, 1'b0, 4'd0);

    // ---- No lock: timeouts up to retry_count=3, then a one-cycle reset mid-WAIT ----
    reset  = 1'b1;
    locked = 1'b0;
    step(1);                                   // E0
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(4111 + ((k == 1) ? 0 : 0));         // one edge before the k-th timeout
      check_outs("to3_wait", S_WAIT, 1'b0, 4'(k - 1));
      step(1);                                 // timeout edge
      check_outs("to3_retry", S_PLL, 1'b0, 4'(k));
    end
    step(116);                                 // 100 cycles into WAIT
    check_outs("to3_midwait", S_WAIT, 1'b0, 4'd3);
    reset = 1'b1;
    step(1);                                   // new E0
    check_outs("midwait_reset", S_PLL, 1'b0, 4'd0);
    reset = 1'b0;
    step(15);
    check_outs("restart_E15", S_PLL, 1'b0, 4'd0);
    step(1);
    check_outs("restart_E16", S_WAIT, 1'b0, 4'd0);

    // ---- Continue without lock: retry_count climbs to 15 and saturates ----
    step(4095);                                // E4111
    check_outs("sat_wait_1", S_WAIT, 1'b0, 4'd0);
    step(1);                                   // E4112
    check_outs("sat_retry_1", S_PLL, 1'b0, 4'd1);
    for (int k = 2; k <= 16; k++) begin
      step(15);                                // last PLL_RST cycle of this attempt
      check_outs("sat_pll_end", S_PLL, 1'b0, 4'((k - 1 > 15) ? 15 : k - 1));
      step(1);
      check_outs("sat_wait_start", S_WAIT, 1'b0, 4'((k - 1 > 15) ? 15 : k - 1));
      step(4095);
      check_outs("sat_wait_end", S_WAIT, 1'b0, 4'((k - 1 > 15) ? 15 : k - 1));
      step(1);
      check_outs("sat_retry", S_PLL, 1'b0, 4'((k > 15) ? 15 : k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
